// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V core: fetch/decode/execute/mem/writeback
// sequencing, memory request handshakes with a wait-state timeout, and a retire counter.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_alu_op,
    input  logic             i_we,
    input  logic             i_branch_taken,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_imem_req,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic [1:0]       o_pc_src,
    output logic             o_rf_we,
    output logic [1:0]       o_wb_sel,
    output logic [2:0]       o_state,
    output logic             o_illegal,
    output logic             o_bus_error,
    output logic [CNT_W-1:0] o_instr_count
);

    // Handshake protocol: a request stays high until its ready is seen high in the
    // same cycle; ready while the matching request is low has no effect.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [3:0] OP_LOAD    = 4'h2;
    localparam logic [3:0] OP_STORE   = 4'h3;
    localparam logic [3:0] OP_JUMP    = 4'h5;
    localparam logic [3:0] OP_BRANCH  = 4'h8;
    localparam logic [3:0] OP_ILLEGAL = 4'hF;

    // The counter only ever holds 0..TIMEOUT-1: the cycle it would reach TIMEOUT
    // is the cycle the FSM leaves for HALT.
    localparam int               WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TO_EN     = (TIMEOUT > 0);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_class;
    logic               r_we;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_illegal;
    logic               r_bus_error;
    logic [CNT_W-1:0]   r_instr_count;

    logic               w_timeout;
    logic               w_wait_clear;
    logic               w_wait_inc;
    logic               w_set_illegal;
    logic               w_set_bus_error;
    logic               w_capture_class;
    logic               w_imem_req;
    logic               w_dmem_req;
    logic               w_dmem_we;
    logic               w_ir_write;
    logic               w_pc_write;
    logic [1:0]         w_pc_src;
    logic               w_rf_we;
    logic [1:0]         w_wb_sel;

    assign w_timeout = TO_EN && (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_clear    = 1'b0;
        w_wait_inc      = 1'b0;
        w_set_illegal   = 1'b0;
        w_set_bus_error = 1'b0;
        w_capture_class = 1'b0;
        w_imem_req      = 1'b0;
        w_dmem_req      = 1'b0;
        w_dmem_we       = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_src        = 2'b00;
        w_rf_we         = 1'b0;
        w_wb_sel        = 2'b00;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
                w_wait_clear = 1'b1;
            end

            S_FETCH: begin
                w_imem_req = 1'b1;
                if (i_imem_ready) begin
                    w_ir_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_error = 1'b1;
                    w_next_state    = S_HALT;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_DECODE: begin
                w_capture_class = 1'b1;
                if (i_alu_op == OP_ILLEGAL) begin
                    w_set_illegal = 1'b1;
                    w_next_state  = S_HALT;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                if ((r_class == OP_LOAD) || (r_class == OP_STORE)) begin
                    w_wait_clear = 1'b1;
                    w_next_state = S_MEM;
                end else if (r_class == OP_BRANCH) begin
                    w_pc_write   = 1'b1;
                    w_pc_src     = {1'b0, i_branch_taken};
                    w_wait_clear = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_WB;
                end
            end

            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_class == OP_STORE);
                if (i_dmem_ready) begin
                    if (r_class == OP_STORE) begin
                        w_pc_write   = 1'b1;
                        w_wait_clear = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else if (w_timeout) begin
                    w_set_bus_error = 1'b1;
                    w_next_state    = S_HALT;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_WB: begin
                w_rf_we      = r_we;
                w_pc_write   = 1'b1;
                w_wait_clear = 1'b1;
                w_next_state = S_FETCH;
                if (r_class == OP_LOAD) begin
                    w_wb_sel = 2'b01;
                end else if (r_class == OP_JUMP) begin
                    w_wb_sel = 2'b10;
                    w_pc_src = 2'b01;
                end
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Class and write request are latched leaving DECODE so later states ignore
    // whatever the decoder shows after the IR moves on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_class <= 4'h0;
            r_we    <= 1'b0;
        end else if (w_capture_class) begin
            r_class <= i_alu_op;
            r_we    <= i_we;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (w_wait_clear) begin
            r_wait_cnt <= '0;
        end else if (w_wait_inc) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_error) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    // Every retiring path updates the PC exactly once, so the PC strobe is the retire event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr_count <= '0;
        end else if (w_pc_write) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign o_imem_req    = w_imem_req;
    assign o_dmem_req    = w_dmem_req;
    assign o_dmem_we     = w_dmem_we;
    assign o_ir_write    = w_ir_write;
    assign o_pc_write    = w_pc_write;
    assign o_pc_src      = w_pc_src;
    assign o_rf_we       = w_rf_we;
    assign o_wb_sel      = w_wb_sel;
    assign o_state       = r_state;
    assign o_illegal     = r_illegal;
    assign o_bus_error   = r_bus_error;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle traces are generated from the
// instruction-class rules and compared cycle by cycle against the DUT outputs.
module tb_multicycle_control;

    localparam int TO    = 4;
    localparam int CNT_W = 8;

    logic             i_clk;
    logic             i_rst;
    logic [3:0]       i_alu_op;
    logic             i_we;
    logic             i_branch_taken;
    logic             i_imem_ready;
    logic             i_dmem_ready;
    logic             o_imem_req;
    logic             o_dmem_req;
    logic             o_dmem_we;
    logic             o_ir_write;
    logic             o_pc_write;
    logic [1:0]       o_pc_src;
    logic             o_rf_we;
    logic [1:0]       o_wb_sel;
    logic [2:0]       o_state;
    logic             o_illegal;
    logic             o_bus_error;
    logic [CNT_W-1:0] o_instr_count;

    multicycle_control #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_alu_op(i_alu_op), .i_we(i_we),
        .i_branch_taken(i_branch_taken), .i_imem_ready(i_imem_ready),
        .i_dmem_ready(i_dmem_ready), .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
        .o_pc_src(o_pc_src), .o_rf_we(o_rf_we), .o_wb_sel(o_wb_sel), .o_state(o_state),
        .o_illegal(o_illegal), .o_bus_error(o_bus_error), .o_instr_count(o_instr_count)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected per-cycle outputs {state,ireq,dreq,dwe,irw,pcw,pcsrc,rfwe,wbsel,ill,bus}
    // and the inputs to apply in that cycle {alu_op,we,bt,imem_ready,dmem_ready}.
    logic [14:0] exp_q[$];
    logic [7:0]  in_q[$];
    logic        m_ill;
    logic        m_bus;
    logic        m_halted;
    logic [CNT_W-1:0] m_cnt;

    function automatic logic [14:0] mk(input logic [2:0] s, input logic ireq, input logic dreq,
                                       input logic dwe, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic rfw, input logic [1:0] wbs);
        return {s, ireq, dreq, dwe, irw, pcw, pcs, rfw, wbs, m_ill, m_bus};
    endfunction

    function automatic logic [14:0] dut_out();
        return {o_state, o_imem_req, o_dmem_req, o_dmem_we, o_ir_write, o_pc_write,
                o_pc_src, o_rf_we, o_wb_sel, o_illegal, o_bus_error};
    endfunction

    function automatic logic [7:0] rnd_in(input logic ir, input logic dr);
        return {4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), ir, dr};
    endfunction

    // driver tasks
    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
            in_q.push_back(rnd_in(1'($urandom), 1'($urandom)));
        end
        m_halted = 1'b1;
    endtask

    // Trace of one instruction from fetch to retire; iw/dw are ready delays in cycles.
    task automatic gen_instr(input logic [3:0] op, input logic w, input logic bt,
                             input int iw, input int dw);
        int  n;
        logic rdy;
        logic is_mem;
        logic is_st;
        if (m_halted) return;
        n = (iw >= TO) ? TO : iw + 1;
        for (int i = 0; i < n; i++) begin
            rdy = (i == iw);
            exp_q.push_back(mk(3'd1, 1, 0, 0, rdy, 0, 2'b00, 0, 2'b00));
            in_q.push_back(rnd_in(rdy, 1'($urandom)));
        end
        if (iw >= TO) begin
            m_bus = 1'b1;
            push_halt(3);
            return;
        end
        exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        in_q.push_back({op, w, 1'($urandom), 1'($urandom), 1'($urandom)});
        if (op == 4'hF) begin
            m_ill = 1'b1;
            push_halt(4);
            return;
        end
        if (op == 4'h8) begin
            exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 1, {1'b0, bt}, 0, 2'b00));
            in_q.push_back({4'($urandom_range(0, 15)), 1'($urandom), bt, 1'($urandom), 1'($urandom)});
            return;
        end
        exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        in_q.push_back(rnd_in(1'($urandom), 1'($urandom)));
        is_mem = (op == 4'h2) || (op == 4'h3);
        is_st  = (op == 4'h3);
        if (is_mem) begin
            n = (dw >= TO) ? TO : dw + 1;
            for (int j = 0; j < n; j++) begin
                rdy = (j == dw);
                exp_q.push_back(mk(3'd4, 0, 1, is_st, 0, is_st && rdy, 2'b00, 0, 2'b00));
                in_q.push_back(rnd_in(1'($urandom), rdy));
            end
            if (dw >= TO) begin
                m_bus = 1'b1;
                push_halt(3);
                return;
            end
            if (is_st) return;
        end
        exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 1, (op == 4'h5) ? 2'b01 : 2'b00, w,
                           (op == 4'h2) ? 2'b01 : ((op == 4'h5) ? 2'b10 : 2'b00)));
        in_q.push_back(rnd_in(1'($urandom), 1'($urandom)));
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic run_n(input int n);
        logic [14:0] e;
        logic [7:0]  in;
        for (int k = 0; k < n && exp_q.size() > 0; k++) begin
            e  = exp_q.pop_front();
            in = in_q.pop_front();
            {i_alu_op, i_we, i_branch_taken, i_imem_ready, i_dmem_ready} = in;
            @(negedge i_clk);
            checks++;
            if (dut_out() !== e) begin
                errors++;
                $display("FAIL trace cyc=%0d got=%h exp=%h (state/ireq/dreq/dwe/irw/pcw/pcsrc/rfwe/wbsel/ill/bus)",
                         cyc, dut_out(), e);
            end
            checks++;
            if (o_instr_count !== m_cnt) begin
                errors++;
                $display("FAIL instr_count cyc=%0d got=%0d exp=%0d", cyc, o_instr_count, m_cnt);
            end
            if (e[7]) m_cnt = m_cnt + 1'b1;
            cyc++;
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic run_all();
        run_n(exp_q.size());
    endtask

    // Leaves the bench at posedge+1 with reset just released; the IDLE cycle is queued.
    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst    = 1'b0;
        m_cnt    = '0;
        m_ill    = 1'b0;
        m_bus    = 1'b0;
        m_halted = 1'b0;
        exp_q.delete();
        in_q.delete();
        exp_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        in_q.push_back(rnd_in(1'($urandom), 1'($urandom)));
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        {i_alu_op, i_we, i_branch_taken, i_imem_ready, i_dmem_ready} = rnd_in(1'b1, 1'b1);
        repeat (2) @(negedge i_clk);
        checks++;
        if (dut_out() !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", dut_out());
        end
        checks++;
        if (o_instr_count !== '0) begin
            errors++;
            $display("FAIL reset_count got=%0d exp=0", o_instr_count);
        end
    endtask

    task automatic test_first_add();
        do_reset();
        gen_instr(4'h0, 1'b1, 1'b0, 0, 0);
        gen_instr(4'h0, 1'b1, 1'b0, 0, 0);
        run_all();
    endtask

    task automatic test_load_wait();
        gen_instr(4'h2, 1'b1, 1'b0, 0, 3);
        gen_instr(4'h3, 1'b0, 1'b0, 1, 0);
        run_all();
    endtask

    task automatic test_branch();
        gen_instr(4'h8, 1'b1, 1'b1, 0, 0);
        gen_instr(4'h8, 1'b1, 1'b0, 0, 0);
        gen_instr(4'h5, 1'b1, 1'b0, 0, 0);
        run_all();
    endtask

    task automatic test_random();
        logic [3:0] op;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 8));
            gen_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            run_all();
        end
    endtask

    task automatic test_illegal();
        do_reset();
        gen_instr(4'h1, 1'b1, 1'b0, 0, 0);
        gen_instr(4'hF, 1'b1, 1'b0, 0, 0);
        run_all();
        do_reset();
        gen_instr(4'h6, 1'b1, 1'b0, 0, 0);
        run_all();
    endtask

    task automatic test_timeout();
        do_reset();
        gen_instr(4'h0, 1'b1, 1'b0, TO, 0);
        run_all();
        do_reset();
        gen_instr(4'h7, 1'b1, 1'b0, TO - 1, 0);
        gen_instr(4'h3, 1'b0, 1'b0, 0, TO - 1);
        gen_instr(4'h3, 1'b0, 1'b0, 0, TO);
        run_all();
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        gen_instr(4'h3, 1'b0, 1'b0, 0, 3);
        run_n(6);
        i_imem_ready = 1'b0;
        i_dmem_ready = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_dmem_req !== 1'b0 || o_state !== 3'd0) begin
            errors++;
            $display("FAIL async_reset dmem_req=%b state=%0d exp dmem_req=0 state=0", o_dmem_req, o_state);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_state !== 3'd1 || o_imem_req !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fetch state=%0d imem_req=%b exp state=1 imem_req=1", o_state, o_imem_req);
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        m_cnt = '0; m_ill = 1'b0; m_bus = 1'b0; m_halted = 1'b0;
        test_reset();
        test_first_add();
        test_load_wait();
        test_branch();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multi-cycle RISC-V core.
- Sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Consumes the class signals produced by the instruction decoder and drives the PC, IR, register-file and memory strobes.
- Owns the instruction/data memory request handshakes, a wait-state timeout, and a retired-instruction counter.

Parameters:
- TIMEOUT, 16: max wait cycles for imem_ready/dmem_ready before bus error; 0 disables the timeout.
- CNT_W, 32: width of instr_count.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_op  in  4  decoder class: 0 ADD, 1 ADDI, 2 LOAD, 3 STORE, 4 LUI, 5 JUMP, 6 OR, 7 AND, 8 BRANCH, F illegal
- we  in  1  decoder register-write request
- branch_taken  in  1  ALU compare result, valid in EXECUTE
- imem_ready  in  1  instruction memory done, sampled while imem_req=1
- dmem_ready  in  1  data memory done, sampled while dmem_req=1
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data request is a write
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC this cycle
- pc_src  out  2  00 = pc+4, 01 = pc+imm
- rf_we  out  1  register-file write strobe
- wb_sel  out  2  00 = ALU, 01 = memory data, 10 = pc+4
- state  out  3  current state, for debug
- illegal  out  1  sticky; illegal opcode seen
- bus_error  out  1  sticky; handshake timeout
- instr_count  out  CNT_W  retired instructions

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
- Reset (asynchronous, any time, including mid-handshake):
  - state=IDLE; wait counter, instr_count, illegal and bus_error = 0.
  - All strobes 0, pc_src=00, wb_sel=00.
  - An outstanding request is dropped; no retry bookkeeping.
- Outputs decode from state and registered class bits only. No combinational path from alu_op to any strobe except in the EXECUTE and WB decisions below.
- alu_op is sampled and held in an internal class register at the end of DECODE. EXECUTE, MEM and WB use this held class.
- IDLE: all outputs 0; go to FETCH next cycle.
- FETCH:
  - imem_req=1 until imem_ready.
  - In the cycle imem_ready=1: ir_write=1 (single-cycle pulse), then go to DECODE.
- DECODE: one cycle.
  - alu_op=F: go to HALT, set illegal.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - LOAD or STORE: go to MEM.
  - BRANCH: pc_write=1; pc_src=01 if branch_taken else 00; retire; go to FETCH.
  - Any other class: go to WB.
- MEM:
  - dmem_req=1 until dmem_ready; dmem_we=1 for STORE only.
  - On dmem_ready, STORE: pc_write=1, pc_src=00, retire, go to FETCH.
  - On dmem_ready, LOAD: go to WB.
- WB: one cycle.
  - rf_we = held we; pc_write=1; retire; go to FETCH.
  - wb_sel=01 for LOAD, 10 for JUMP, 00 otherwise.
  - pc_src=01 for JUMP, 00 otherwise.
- Retire: instr_count increments by 1 in the pc_write cycle. It wraps modulo 2^CNT_W without flagging.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle the request is held with ready=0.
  - If it reaches TIMEOUT (TIMEOUT>0): go to HALT and set bus_error. No strobe fires in that cycle.
  - A ready arriving in the same cycle the counter reaches TIMEOUT wins; completion has priority.
- HALT:
  - All strobes 0; illegal and bus_error hold their values.
  - Exit only by reset.
- ready asserted while the matching req=0 is ignored.
- Zero-wait latency (cycles per instruction): ALU/LUI/JUMP 4, LOAD 5, STORE 4, BRANCH 3.
- Every wait cycle adds one cycle.

Test Plan:
- Reset release with imem_ready=1, alu_op=0 (ADD), we=1 → states 0,1,2,3,5,1.
  - ir_write pulses in the cycle state=1; rf_we=1, wb_sel=00, pc_write=1 in the cycle state=5.
  - instr_count goes 0→1 on the following clock edge.
- LOAD with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with dmem_we=0; then WB with wb_sel=01; 8 cycles total.
- BRANCH with branch_taken=1, then a second BRANCH with branch_taken=0 → pc_src=01, then 00, each in EXECUTE; rf_we stays 0; 3 cycles each.
- alu_op=F in DECODE → state=6 and illegal=1 from the next cycle; no further imem_req.
  - instr_count is unchanged; rst clears all of this.
- TIMEOUT=4 with imem_ready held 0 → imem_req high for 4 cycles, then state=6 and bus_error=1.
  - Repeat with ready arriving in the 4th cycle → normal DECODE, bus_error=0.
- Assert rst in the middle of a STORE MEM wait → dmem_req drops immediately (asynchronously) and state=0.
  - One cycle after release, state=1 and imem_req=1.
